// File: rtl/chaotic_euler_step.sv
// Pipelined fixed-point Euler step zn1 = zn + ((tao*yn) >>> FRAC_BITS) followed by a programmable alignment delay.
// Build option: define EULER_SAT_EN to clamp overflowing results instead of wrapping them.
module chaotic_euler_step #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FRAC_BITS  = 24,
  parameter int unsigned DLY_W      = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic signed [DATA_WIDTH-1:0] tao,
  input  logic        [DLY_W-1:0]      dly,
  input  logic                         in_valid,
  input  logic signed [DATA_WIDTH-1:0] yn,
  input  logic signed [DATA_WIDTH-1:0] zn,
  input  logic                         ovf_clr,
  output logic                         out_valid,
  output logic signed [DATA_WIDTH-1:0] zn1,
  output logic                         busy,
  output logic                         ovf_flag,
  output logic        [15:0]           ovf_cnt
);

  localparam int unsigned PROD_W = 2 * DATA_WIDTH;
  localparam int unsigned SUM_W  = PROD_W + 1;
  localparam int unsigned DEPTH  = 1 << DLY_W;
  localparam int unsigned CNT_W  = DLY_W + 3;
  localparam logic [DATA_WIDTH-1:0] MAX_V = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] MIN_V = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  logic                         r_s1_v;
  logic signed [DATA_WIDTH-1:0] r_s1_tao;
  logic signed [DATA_WIDTH-1:0] r_s1_yn;
  logic signed [DATA_WIDTH-1:0] r_s1_zn;
  logic                         r_s2_v;
  logic signed [PROD_W-1:0]     r_s2_prod;
  logic signed [DATA_WIDTH-1:0] r_s2_zn;

  logic signed [PROD_W-1:0]     w_prod;
  logic signed [PROD_W-1:0]     w_shift;
  logic signed [SUM_W-1:0]      w_sum;
  logic                         w_ovf;
  logic                         w_ovf_ev;
  logic        [DATA_WIDTH-1:0] w_res;

  logic        [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic        [DEPTH-1:0]      r_bvld;
  logic        [DLY_W-1:0]      r_wp;
  logic        [DLY_W-1:0]      w_rp;
  logic        [DLY_W-1:0]      r_dly_q;
  logic                         w_bypass;

  logic                         r_out_valid;
  logic        [DATA_WIDTH-1:0] r_zn1;
  logic        [CNT_W-1:0]      r_cnt;
  logic        [CNT_W-1:0]      w_cnt_nxt;
  logic                         r_busy;
  logic                         r_ovf_flag;
  logic        [15:0]           r_ovf_cnt;

  // S1: capture the operands of each accepted sample
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_v   <= 1'b0;
      r_s1_tao <= '0;
      r_s1_yn  <= '0;
      r_s1_zn  <= '0;
    end else begin
      r_s1_v <= in_valid;
      if (in_valid) begin
        r_s1_tao <= tao;
        r_s1_yn  <= yn;
        r_s1_zn  <= zn;
      end
    end
  end

  assign w_prod = PROD_W'(r_s1_tao) * PROD_W'(r_s1_yn);

  // S2: full-precision signed product
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s2_v    <= 1'b0;
      r_s2_prod <= '0;
      r_s2_zn   <= '0;
    end else begin
      r_s2_v <= r_s1_v;
      if (r_s1_v) begin
        r_s2_prod <= w_prod;
        r_s2_zn   <= r_s1_zn;
      end
    end
  end

  // S3: floor-rescale, widen, accumulate and range-check
  assign w_shift  = r_s2_prod >>> FRAC_BITS;
  assign w_sum    = SUM_W'(w_shift) + SUM_W'(r_s2_zn);
  assign w_ovf    = (w_sum[SUM_W-1:DATA_WIDTH-1] != {(SUM_W-DATA_WIDTH+1){w_sum[SUM_W-1]}});
  assign w_ovf_ev = r_s2_v & w_ovf;

`ifdef EULER_SAT_EN
  assign w_res = w_ovf ? (w_sum[SUM_W-1] ? MIN_V : MAX_V) : w_sum[DATA_WIDTH-1:0];
`else
  assign w_res = w_sum[DATA_WIDTH-1:0];
`endif

  assign w_bypass = (r_dly_q == '0);
  assign w_rp     = r_wp - r_dly_q;

  // Alignment buffer: entries are invalidated on read so a later, longer delay never replays them
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wp   <= '0;
      r_bvld <= '0;
    end else begin
      r_wp <= r_wp + DLY_W'(1);
      if (!w_bypass) begin
        r_bvld[w_rp] <= 1'b0;
        r_bvld[r_wp] <= r_s2_v;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (r_s2_v && !w_bypass) begin
      r_mem[r_wp] <= w_res;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_zn1       <= '0;
    end else if (w_bypass) begin
      r_out_valid <= r_s2_v;
      if (r_s2_v) r_zn1 <= w_res;
    end else begin
      r_out_valid <= r_bvld[w_rp];
      if (r_bvld[w_rp]) r_zn1 <= r_mem[w_rp];
    end
  end

  // In-flight tracking; the delay setting is frozen while anything is in flight
  assign w_cnt_nxt = r_cnt + CNT_W'(in_valid) - CNT_W'(r_out_valid);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_dly_q <= '0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_busy <= (w_cnt_nxt != '0);
      if (!r_busy) r_dly_q <= dly;
    end
  end

  // Overflow bookkeeping; a coinciding event survives the clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf_flag <= 1'b0;
      r_ovf_cnt  <= '0;
    end else if (ovf_clr) begin
      r_ovf_flag <= w_ovf_ev;
      r_ovf_cnt  <= 16'(w_ovf_ev);
    end else if (w_ovf_ev) begin
      r_ovf_flag <= 1'b1;
      if (r_ovf_cnt != 16'hFFFF) r_ovf_cnt <= r_ovf_cnt + 16'd1;
    end
  end

  assign out_valid = r_out_valid;
  assign zn1       = r_zn1;
  assign busy      = r_busy;
  assign ovf_flag  = r_ovf_flag;
  assign ovf_cnt   = r_ovf_cnt;

endmodule

// File: tb/tb_chaotic_euler_step.sv
// Directed bench for chaotic_euler_step (DATA_WIDTH=32, FRAC_BITS=24, DLY_W=8); honours EULER_SAT_EN.
module tb_chaotic_euler_step;

  logic               clk = 1'b0;
  logic               rst;
  logic signed [31:0] tao;
  logic        [7:0]  dly;
  logic               in_valid;
  logic signed [31:0] yn;
  logic signed [31:0] zn;
  logic               ovf_clr;
  logic               out_valid;
  logic signed [31:0] zn1;
  logic               busy;
  logic               ovf_flag;
  logic        [15:0] ovf_cnt;

  int checks = 0;
  int errors = 0;

  chaotic_euler_step #(.DATA_WIDTH(32), .FRAC_BITS(24), .DLY_W(8)) dut (
    .clk(clk), .rst(rst), .tao(tao), .dly(dly), .in_valid(in_valid),
    .yn(yn), .zn(zn), .ovf_clr(ovf_clr), .out_valid(out_valid), .zn1(zn1),
    .busy(busy), .ovf_flag(ovf_flag), .ovf_cnt(ovf_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One sample, then wait (bounded) for its result; lat = -1 on timeout
  task automatic send(input logic [31:0] t, input logic [31:0] y, input logic [31:0] z,
                      input logic [7:0] new_dly, output int lat, output logic [31:0] res);
    tao = t; yn = y; zn = z; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    dly = new_dly;
    lat = -1;
    for (int k = 1; k <= 300; k++) begin
      if (out_valid) begin
        lat = k;
        break;
      end
      tick();
    end
    res = zn1;
  endtask

  int          lat;
  logic [31:0] res;
  logic [31:0] exp_pos;
  logic [31:0] exp_neg;
  int          n_out;
  int          first_c;
  int          last_c;
  int          stray;

  initial begin
`ifdef EULER_SAT_EN
    exp_pos = 32'h7FFF_FFFF;
    exp_neg = 32'h8000_0000;
`else
    exp_pos = 32'h8100_0000;
    exp_neg = 32'h7F00_0000;
`endif
    rst = 1'b1; tao = '0; yn = '0; zn = '0; dly = 8'd0; in_valid = 1'b0; ovf_clr = 1'b0;
    tick();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_zn1",       64'(zn1),       64'd0);
    check("rst_busy",      64'(busy),      64'd0);
    check("rst_ovf_flag",  64'(ovf_flag),  64'd0);
    check("rst_ovf_cnt",   64'(ovf_cnt),   64'd0);
    rst = 1'b0;
    tick();

    // Basic step, no alignment delay
    send(32'h0040_0000, 32'h0200_0000, 32'h0100_0000, 8'd0, lat, res);
    check("d0_latency", 64'(lat), 64'd3);
    check("d0_zn1",     64'(res), 64'h0180_0000);
    tick();
    check("hold_out_valid", 64'(out_valid), 64'd0);
    check("hold_zn1",       64'(zn1),       64'h0180_0000);
    check("idle_busy",      64'(busy),      64'd0);

    // Same sample through a 5-cycle alignment delay
    dly = 8'd5;
    tick();
    send(32'h0040_0000, 32'h0200_0000, 32'h0100_0000, 8'd5, lat, res);
    check("d5_latency", 64'(lat), 64'd8);
    check("d5_zn1",     64'(res), 64'h0180_0000);
    tick();

    // 20 back-to-back samples: zn1 = i*2^16 + 0x100
    n_out = 0; first_c = -1; last_c = -1;
    for (int c = 0; c < 40; c++) begin
      in_valid = (c < 20);
      tao = 32'h0100_0000;
      yn  = 32'(c) << 16;
      zn  = 32'h0000_0100;
      tick();
      if (out_valid) begin
        check($sformatf("burst_zn1_%0d", n_out), 64'(zn1), 64'((n_out << 16) + 32'h100));
        if (n_out == 0) first_c = c + 1;
        last_c = c + 1;
        n_out++;
      end
    end
    in_valid = 1'b0;
    check("burst_count", 64'(n_out),   64'd20);
    check("burst_first", 64'(first_c), 64'd8);
    check("burst_last",  64'(last_c),  64'd27);
    check("burst_busy",  64'(busy),    64'd0);

    // Overflow positive, negative, and exact upper bound
    dly = 8'd0;
    tick();
    send(32'h0100_0000, 32'h0200_0000, 32'h7F00_0000, 8'd0, lat, res);
    check("ovfp_latency", 64'(lat),      64'd3);
    check("ovfp_zn1",     64'(res),      64'(exp_pos));
    check("ovfp_flag",    64'(ovf_flag), 64'd1);
    check("ovfp_cnt",     64'(ovf_cnt),  64'd1);
    send(32'h0100_0000, 32'hFF00_0000, 32'h8000_0000, 8'd0, lat, res);
    check("ovfn_zn1", 64'(res),     64'(exp_neg));
    check("ovfn_cnt", 64'(ovf_cnt), 64'd2);
    send(32'h0100_0000, 32'h00FF_FFFF, 32'h7F00_0000, 8'd0, lat, res);
    check("max_zn1", 64'(res),     64'h7FFF_FFFF);
    check("max_cnt", 64'(ovf_cnt), 64'd2);

    // Floor truncation, and dly change ignored while busy
    dly = 8'd3;
    tick();
    send(32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 8'd7, lat, res);
    check("floor_zn1",     64'(res), 64'hFFFF_FFFF);
    check("frozen_latency", 64'(lat), 64'd6);
    for (int k = 0; k < 20; k++) begin
      if (!busy) break;
      tick();
    end
    check("drain_busy", 64'(busy), 64'd0);
    send(32'h0040_0000, 32'h0200_0000, 32'h0100_0000, 8'd7, lat, res);
    check("d7_latency", 64'(lat), 64'd10);
    check("d7_zn1",     64'(res), 64'h0180_0000);
    tick();

    // Reset with 4 samples in flight
    for (int i = 0; i < 4; i++) begin
      tao = 32'h0100_0000; yn = 32'h0200_0000; zn = 32'h7F00_0000; in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    dly = 8'd0;
    rst = 1'b0;
    check("rst2_busy",     64'(busy),      64'd0);
    check("rst2_ovf_cnt",  64'(ovf_cnt),   64'd0);
    check("rst2_ovf_flag", 64'(ovf_flag),  64'd0);
    stray = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (out_valid) stray++;
    end
    check("rst2_no_output", 64'(stray), 64'd0);
    check("rst2_busy_after", 64'(busy), 64'd0);

    // ovf_clr coinciding with an overflow leaves a count of one
    send(32'h0100_0000, 32'h0200_0000, 32'h7F00_0000, 8'd0, lat, res);
    check("clr_pre_cnt", 64'(ovf_cnt), 64'd1);
    tao = 32'h0100_0000; yn = 32'h0200_0000; zn = 32'h7F00_0000; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("clr_coinc_valid", 64'(out_valid), 64'd1);
    check("clr_coinc_flag",  64'(ovf_flag),  64'd1);
    check("clr_coinc_cnt",   64'(ovf_cnt),   64'd1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("clr_only_flag", 64'(ovf_flag), 64'd0);
    check("clr_only_cnt",  64'(ovf_cnt),  64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/chaotic_euler_step.md
CHAOTIC_EULER_STEP -- requirements
Module: chaotic_euler_step

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the signed fixed-point width of tao, yn, zn and zn1.
REQ-002 Parameter FRAC_BITS, default 24, SHALL set the number of fraction bits; legal range 1..DATA_WIDTH-2.
REQ-003 Parameter DLY_W, default 8, SHALL set the width of dly; alignment buffer depth = 2^DLY_W.
REQ-004 clk  in  1  single clock; all state on its rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 tao  in  DATA_WIDTH  signed step size, sampled with in_valid.
REQ-007 dly  in  DLY_W  requested alignment delay in cycles after the core.
REQ-008 in_valid  in  1  yn/zn/tao qualifier; one sample per cycle, no backpressure.
REQ-009 yn  in  DATA_WIDTH  signed derivative term.
REQ-010 zn  in  DATA_WIDTH  signed current state.
REQ-011 ovf_clr  in  1  synchronous clear of ovf_flag and ovf_cnt.
REQ-012 out_valid  out  1  zn1 qualifier.
REQ-013 zn1  out  DATA_WIDTH  signed next state, zn + ((tao*yn) >>> FRAC_BITS).
REQ-014 busy  out  1  high while any sample is in flight.
REQ-015 ovf_flag  out  1  sticky overflow indicator.
REQ-016 ovf_cnt  out  16  overflow event count, saturating at 0xFFFF.

Function
REQ-017 The core SHALL be a 3-stage pipeline: S1 registers inputs; S2 forms the full 2*DATA_WIDTH signed product tao*yn; S3 shifts the product right arithmetically by FRAC_BITS (truncation toward minus infinity), adds sign-extended zn at full width, and resolves the range.
REQ-018 Overflow SHALL be declared when the S3 full-width sum lies outside [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
REQ-019 The core output SHALL pass through a circular alignment buffer of dly_q cycles (write pointer, read = write - dly_q, per-entry valid bit); dly_q = 0 bypasses the buffer.
REQ-020 Total latency in_valid -> out_valid SHALL be exactly 3 + dly_q cycles, with throughput of one sample per cycle and input order preserved.
REQ-021 dly_q SHALL load dly only on cycles when busy is low; changes to dly while busy SHALL be ignored until the pipeline drains.
REQ-022 busy SHALL be driven by an in-flight counter: +1 on in_valid, -1 on out_valid, unchanged when both occur.
REQ-023 out_valid SHALL be high for exactly one cycle per accepted sample; zn1 SHALL hold its last value when out_valid is low.
REQ-024 Each overflowing sample SHALL set ovf_flag and increment ovf_cnt (saturating at 0xFFFF) in the cycle its result leaves S3.
REQ-025 When ovf_clr and an overflow event coincide, ovf_flag SHALL be 1 and ovf_cnt SHALL be 1 afterwards.

Reset
REQ-026 rst SHALL asynchronously clear out_valid, zn1, busy, ovf_flag, ovf_cnt, dly_q, the in-flight counter, the buffer pointers, all pipeline valid bits and all buffer valid bits.
REQ-027 Samples in flight when rst asserts SHALL be discarded; out_valid SHALL stay low until a sample accepted after reset release completes.
REQ-028 dly_q SHALL load dly on the first clock after reset release.

Configuration
REQ-029 Macro EULER_SAT_EN defined: an overflowing result SHALL clamp to 2^(DATA_WIDTH-1)-1 or -2^(DATA_WIDTH-1) according to the sum's sign.
REQ-030 Macro EULER_SAT_EN undefined: an overflowing result SHALL wrap (low DATA_WIDTH bits kept); ovf_flag and ovf_cnt behave identically in both builds.

Verification (DATA_WIDTH=32, FRAC_BITS=24)
REQ-031 tao=0x00400000, yn=0x02000000, zn=0x01000000, dly=0 -> zn1=0x01800000 with out_valid exactly 3 cycles after in_valid.
REQ-032 Same sample with dly=5 -> output 8 cycles after input; 20 back-to-back samples -> 20 consecutive out_valid pulses in input order.
REQ-033 zn=0x7F000000, tao=0x01000000, yn=0x02000000 -> with EULER_SAT_EN zn1=0x7FFFFFFF, without it zn1=0x81000000; in both builds ovf_flag=1 and ovf_cnt=1.
REQ-034 tao=0x00000001, yn=0xFFFFFFFF, zn=0 -> zn1=0xFFFFFFFF (floor truncation); a sample with dly changed 3->7 while busy -> output after 6 cycles, and the next sample after drain -> 10 cycles.
REQ-035 rst pulse with 4 samples in flight -> no out_valid, busy=0, ovf_cnt=0; ovf_clr coincident with an overflow -> ovf_cnt=1.
